// File: rtl/sop_pkg.sv
// Shared types and constants for the sop_mac_bcd sum-of-products engine.
// FSM state encoding, 7-segment patterns and width helpers.
package sop_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        CONV,
        DONE
    } state_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int acc_width(input int w, input int n);
        return 2 * w + clog2(n);
    endfunction

    function automatic longint pow10(input int d);
        longint r;
        r = 1;
        for (int k = 0; k < d; k++) r = r * 10;
        return r;
    endfunction

endpackage

// File: rtl/seg7_dec.sv
// BCD digit to active-low {g..a} segment pattern.
// Non-decimal codes and the blank request both give all segments off.
module seg7_dec
    import sop_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    // Digit lookup with blanking override
    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/sop_mac_bcd.sv
// Sequential sum of products with shift-add multiply and double-dabble BCD.
// Define SOP_LEADING_ZERO_BLANK_EN to blank leading zero digits above digit 0.
module sop_mac_bcd
    import sop_pkg::*;
#(
    parameter int W      = 3,
    parameter int N      = 2,
    parameter int DIGITS = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [N*W-1:0]               op_a,
    input  logic [N*W-1:0]               op_b,
    output logic                         busy,
    output logic                         done,
    output logic [acc_width(W,N)-1:0]    sum,
    output logic [4*DIGITS-1:0]          bcd,
    output logic [7*DIGITS-1:0]          hex
);

    localparam int ACC_W = acc_width(W, N);
    localparam int IW    = (N > 1) ? clog2(N) : 1;
    localparam int JW    = (W > 1) ? clog2(W) : 1;
    localparam int CW    = clog2(ACC_W + 1);
    localparam int BW    = 4 * DIGITS;

`ifdef SOP_LEADING_ZERO_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    if (pow10(DIGITS) <= longint'(N) * longint'((2**W - 1) * (2**W - 1))) begin : g_bad_digits
        $error("sop_mac_bcd: DIGITS too small for N*(2^W-1)^2");
    end

    state_t             state;
    logic [N*W-1:0]     a_q;
    logic [N*W-1:0]     b_q;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   bin_sr;
    logic [BW-1:0]      bcd_sr;
    logic [IW-1:0]      pi;
    logic [JW-1:0]      pj;
    logic [CW-1:0]      cnt;
    logic [W-1:0]       a_sel;
    logic [W-1:0]       b_sel;
    logic [ACC_W-1:0]   acc_nxt;
    logic [BW-1:0]      adj;
    logic [BW-1:0]      bcd_nxt;
    logic [ACC_W-1:0]   bin_nxt;
    logic [DIGITS-1:0]  blank;
    logic [7*DIGITS-1:0] seg;
    logic               last_j;
    logic               last_i;
    logic               last_c;

    assign busy   = (state == MUL) || (state == CONV);
    assign done   = (state == DONE);
    assign last_j = (pj == JW'(W - 1));
    assign last_i = (pi == IW'(N - 1));
    assign last_c = (cnt == CW'(ACC_W - 1));

    // Select current pair and form the conditional partial product
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int p = 0; p < N; p++) begin
            if (pi == IW'(p)) begin
                a_sel = a_q[p*W +: W];
                b_sel = b_q[p*W +: W];
            end
        end
        acc_nxt = acc;
        if (b_sel[pj]) acc_nxt = acc + (ACC_W'(a_sel) << pj);
    end

    // One double-dabble step: add 3 to nibbles >= 5, then shift left
    always_comb begin
        adj = bcd_sr;
        for (int k = 0; k < DIGITS; k++) begin
            if (adj[4*k +: 4] >= 4'd5) adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
        end
        {bcd_nxt, bin_nxt} = {adj, bin_sr} << 1;
    end

    // Leading-zero blanking flags for the digits about to be registered
    always_comb begin
        logic hz;
        blank = '0;
        hz    = 1'b1;
`ifdef SOP_LEADING_ZERO_BLANK_EN
        for (int k = DIGITS - 1; k >= 1; k--) begin
            hz       = hz && (bcd_nxt[4*k +: 4] == 4'd0);
            blank[k] = hz;
        end
`else
        hz = 1'b0;
`endif
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_dec
        seg7_dec u_dec (
            .digit (bcd_nxt[4*k +: 4]),
            .blank (blank[k]),
            .seg   (seg[7*k +: 7])
        );
    end

    // Control FSM, multiply-accumulate, BCD conversion and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            acc    <= '0;
            bin_sr <= '0;
            bcd_sr <= '0;
            pi     <= '0;
            pj     <= '0;
            cnt    <= '0;
            sum    <= '0;
            bcd    <= '0;
            for (int k = 0; k < DIGITS; k++) begin
                hex[7*k +: 7] <= (BLANK_EN && k > 0) ? SEG_BLANK : SEG_0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= op_a;
                        b_q   <= op_b;
                        acc   <= '0;
                        pi    <= '0;
                        pj    <= '0;
                        state <= MUL;
                    end
                end
                MUL: begin
                    acc <= acc_nxt;
                    if (last_j) begin
                        pj <= '0;
                        if (last_i) begin
                            bin_sr <= acc_nxt;
                            bcd_sr <= '0;
                            cnt    <= '0;
                            state  <= CONV;
                        end else begin
                            pi <= pi + 1'b1;
                        end
                    end else begin
                        pj <= pj + 1'b1;
                    end
                end
                CONV: begin
                    bcd_sr <= bcd_nxt;
                    bin_sr <= bin_nxt;
                    cnt    <= cnt + 1'b1;
                    if (last_c) begin
                        sum   <= acc;
                        bcd   <= bcd_nxt;
                        hex   <= seg;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/sop_mac_bcd.md
# sop_mac_bcd

Sequential sum-of-products engine: computes P = Σ A[i]·B[i] for N operand pairs using a shared shift-add multiplier. It converts P to BCD by sequential double-dabble and drives one active-low 7-segment pattern per decimal digit. It is the clocked, parametrised successor of the combinational AxB+CxD-to-HEX datapath and sits between switch/operand registers and the HEX display bank.

## Interface
- W, default 3: operand width in bits
- N, default 2: number of product pairs
- DIGITS, default 3: decimal digits shown; must satisfy 10^DIGITS > N·(2^W−1)², checked at elaboration
- Derived: ACC_W = 2·W + clog2(N); default 7
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only in IDLE
- op_a  in  N·W  A operands; pair i at [i·W +: W]
- op_b  in  N·W  B operands; pair i at [i·W +: W]
- busy  out  1  high in MUL and CONV
- done  out  1  one-cycle pulse; results valid from this cycle
- sum  out  ACC_W  binary P
- bcd  out  4·DIGITS  BCD of P; digit 0 (units) at [3:0]
- hex  out  7·DIGITS  segment patterns, active-low {g..a}; digit k at [7k +: 7]

## Operation
- States: IDLE, MUL, CONV, DONE.
- IDLE: when start=1 at a rising edge, op_a/op_b are latched, the accumulator is cleared, pair index i=0, bit index j=0, and the state goes to MUL.
- MUL: one cycle per (i, j). If latched B[i][j]=1, the accumulator adds A[i] << j. After j=W−1, i increments. After the last pair, the state goes to CONV. Total N·W cycles.
- CONV: ACC_W cycles of double-dabble. Each cycle, every BCD nibble ≥5 gets +3, then the {bcd, bin} shift register shifts left by 1. After ACC_W cycles, the state goes to DONE.
- DONE: one cycle. sum, bcd and hex registers are updated on the edge entering DONE. done=1. The state goes to IDLE next.
- start is ignored in MUL, CONV and DONE. It is not queued.
- Latched operands are used for the whole computation, so op_a/op_b may change after acceptance.
- sum, bcd and hex hold their last value until the next DONE.
- Segment encoding, active-low: 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0010000. Any other value →1111111.
- Arithmetic is unsigned. The accumulator is ACC_W wide and cannot overflow for the legal parameter range.

## Timing
- Reset values, asserted asynchronously and held while rst_n=0: state IDLE, busy=0, done=0, sum=0, bcd=0.
- hex reset value: every digit =1000000. With blanking compiled in, digit 0 =1000000 and all others =1111111.
- Reset mid-operation aborts the computation immediately. No done pulse is produced.
- Latency: start accepted at edge E. busy=1 from cycle E+1 through E+N·W+ACC_W. done=1 in cycle E+N·W+ACC_W+1, which is 14 for the defaults.
- Earliest next accept: the edge that ends the DONE cycle is not an accept. The first accept is one cycle later, in IDLE.
- Zero operands still take the full latency.

## Configuration
- SOP_LEADING_ZERO_BLANK_EN defined: digit k>0 shows 1111111 when it and all higher digits are 0. Digit 0 is never blanked.
- Not defined: all DIGITS digits are always shown, including leading zeros.
- bcd and sum are identical in both builds.

## Structure
- Package sop_pkg holds:
  - state enum (IDLE, MUL, CONV, DONE)
  - the 10 segment-pattern constants and the blank pattern
  - clog2 function
  - ACC_W computation helper
- One sub-module, seg7_dec: 4-bit BCD plus blank input → 7-bit active-low pattern. It is instantiated DIGITS times.
- FSM, multiplier accumulator and double-dabble shifter live in sop_mac_bcd.

## Test plan
- Defaults, A0=7 B0=7 A1=7 B1=7, start → done at E+14, sum=98, bcd=0x098, hex digit2=1000000 (blanked build: 1111111), digit1=0010000, digit0=0000000.
- Defaults, A0=5 B0=3 A1=2 B1=6 → sum=27, bcd=0x027. Change op_a during MUL → result still 27.
- All operands 0 → done at E+14, sum=0, every digit 1000000. Blanked build: digit0=1000000, others 1111111.
- Pulse start again while busy → ignored. Exactly one done pulse. A new start one cycle after DONE is accepted.
- Deassert rst_n in cycle E+5, release → busy=0, done=0, sum=0, no done pulse. Next run produces a correct result.
- W=4, N=4, DIGITS=3, all operands 15 → ACC_W=10, done at E+27, sum=900, bcd=0x900.
